// File: rtl/sdpram_fifo_ctrl_if.sv
// sdpram_fifo_ctrl_if: FIFO streams, status and RAM port signals of sdpram_fifo_ctrl
// hwm exists only when SDPRAM_FIFO_HWM_EN is defined
interface sdpram_fifo_ctrl_if #(parameter int ADDR_W = 10, parameter int DATA_W = 32);
  logic wr_valid, wr_ready, rd_valid, rd_ready, full, empty, ram_wena, ram_renb;
  logic [DATA_W-1:0] wr_data, rd_data, ram_dina, ram_doutb;
  logic [ADDR_W-1:0] ram_addra, ram_addrb;
  logic [ADDR_W:0] level;
`ifdef SDPRAM_FIFO_HWM_EN
  logic [ADDR_W:0] hwm;
`endif
  modport slave (
    input wr_valid, wr_data, rd_ready, ram_doutb,
    output wr_ready, rd_valid, rd_data, level, full, empty,
    output ram_wena, ram_addra, ram_dina, ram_renb, ram_addrb
`ifdef SDPRAM_FIFO_HWM_EN
    , output hwm
`endif
  );
  modport master (
    output wr_valid, wr_data, rd_ready, ram_doutb,
    input wr_ready, rd_valid, rd_data, level, full, empty,
    input ram_wena, ram_addra, ram_dina, ram_renb, ram_addrb
`ifdef SDPRAM_FIFO_HWM_EN
    , input hwm
`endif
  );
endinterface

// File: rtl/sdpram_fifo_ctrl.sv
// sdpram_fifo_ctrl: first-word-fall-through FIFO controller driving a 1-cycle-latency SDP RAM
// Define SDPRAM_FIFO_HWM_EN to add the hwm high-water-mark register and port.
module sdpram_fifo_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  sdpram_fifo_ctrl_if.slave f
);
  localparam int LW = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0] ram_cnt_q, ram_cnt_d, level_q, level_d;
  logic [1:0] obuf_cnt_q, obuf_cnt_d, cnt_p;
  logic inflight_q, inflight_d, full_q, full_d, empty_q, empty_d;
  logic [DATA_W-1:0] b0_q, b0_d, b1_q, b1_d;
  logic push, pop, issue;
`ifdef SDPRAM_FIFO_HWM_EN
  logic [ADDR_W:0] hwm_q, hwm_d;
`endif
  always_comb begin
    push = f.wr_valid && !full_q;
    pop = (obuf_cnt_q != 2'd0) && f.rd_ready;
    // keep buffered + in-flight words within the 2-entry output buffer
    issue = (ram_cnt_q != '0) && ((obuf_cnt_q + {1'b0, inflight_q} - {1'b0, pop}) < 2'd2);
    wptr_d = wptr_q + ADDR_W'(push);
    rptr_d = rptr_q + ADDR_W'(issue);
    ram_cnt_d = ram_cnt_q + LW'(push) - LW'(issue);
    level_d = level_q + LW'(push) - LW'(pop);
    full_d = level_d == LW'(DEPTH);
    empty_d = level_d == '0;
    inflight_d = issue;
    cnt_p = obuf_cnt_q - {1'b0, pop};
    b0_d = (inflight_q && cnt_p == 2'd0) ? f.ram_doutb : pop ? b1_q : b0_q;
    b1_d = (inflight_q && cnt_p == 2'd1) ? f.ram_doutb : b1_q;
    obuf_cnt_d = cnt_p + {1'b0, inflight_q};
`ifdef SDPRAM_FIFO_HWM_EN
    hwm_d = (level_q > hwm_q) ? level_q : hwm_q;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ram_cnt_q <= '0;
      level_q <= '0;
      obuf_cnt_q <= '0;
      inflight_q <= 1'b0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      b0_q <= '0;
      b1_q <= '0;
`ifdef SDPRAM_FIFO_HWM_EN
      hwm_q <= '0;
`endif
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      level_q <= level_d;
      obuf_cnt_q <= obuf_cnt_d;
      inflight_q <= inflight_d;
      full_q <= full_d;
      empty_q <= empty_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
`ifdef SDPRAM_FIFO_HWM_EN
      hwm_q <= hwm_d;
`endif
    end
  assign f.wr_ready = !full_q;
  assign f.rd_valid = obuf_cnt_q != 2'd0;
  assign f.rd_data = b0_q;
  assign f.level = level_q;
  assign f.full = full_q;
  assign f.empty = empty_q;
  assign f.ram_wena = push;
  assign f.ram_addra = wptr_q;
  assign f.ram_dina = f.wr_data;
  assign f.ram_renb = issue;
  assign f.ram_addrb = rptr_q;
`ifdef SDPRAM_FIFO_HWM_EN
  assign f.hwm = hwm_q;
`endif
endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// tb_sdpram_fifo_ctrl: directed vector table plus fill/drain, streaming and reset sequences
// hwm checks are compiled in only when SDPRAM_FIFO_HWM_EN is defined
module tb_sdpram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  sdpram_fifo_ctrl_if #(.ADDR_W(10), .DATA_W(32)) f();
  sdpram_fifo_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (.clk(clk), .rst(rst), .f(f));
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (f.ram_wena) mem[f.ram_addra] <= f.ram_dina;
    if (f.ram_renb) f.ram_doutb <= mem[f.ram_addrb];
  end
  typedef struct {
    logic wv; logic [31:0] wd; logic rr;
    logic e_wrdy; logic e_rv; logic [31:0] e_rd; int e_lvl; logic e_emp; logic e_wena; int e_addra; logic e_renb;
  } vec_t;
  vec_t v [8];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic drv(input logic wv, input logic [31:0] wd, input logic rr);
    f.wr_valid = wv;
    f.wr_data = wd;
    f.rd_ready = rr;
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input int first, input int n);
    int got = 0;
    int cyc = 0;
    drv(0, 0, 1);
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      if (f.rd_valid) begin
        chk("drain data", f.rd_data, first + got);
        got++;
      end
      nxt;
      cyc++;
    end
    chk("drain count", got, n);
    drv(0, 0, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int acc, pops, pushed, popped;
    v[0] = '{1, 350, 0, 1, 0, 0, 0, 1, 1, 0, 0};
    v[1] = '{1, 670, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    v[2] = '{0, 0, 0, 1, 0, 0, 2, 0, 0, 2, 1};
    v[3] = '{0, 0, 0, 1, 1, 350, 2, 0, 0, 2, 0};
    v[4] = '{0, 0, 1, 1, 1, 350, 2, 0, 0, 2, 0};
    v[5] = '{0, 0, 1, 1, 1, 670, 1, 0, 0, 2, 0};
    v[6] = '{0, 0, 1, 1, 0, 0, 0, 1, 0, 2, 0};
    v[7] = '{0, 0, 1, 1, 0, 0, 0, 1, 0, 2, 0};
    drv(0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst wr_ready", f.wr_ready, 1);
    chk("rst rd_valid", f.rd_valid, 0);
    chk("rst rd_data", f.rd_data, 0);
    chk("rst level", f.level, 0);
    chk("rst full", f.full, 0);
    chk("rst empty", f.empty, 1);
    chk("rst ram_wena", f.ram_wena, 0);
    chk("rst ram_addra", f.ram_addra, 0);
    chk("rst ram_dina", f.ram_dina, 0);
    chk("rst ram_renb", f.ram_renb, 0);
    chk("rst ram_addrb", f.ram_addrb, 0);
`ifdef SDPRAM_FIFO_HWM_EN
    chk("rst hwm", f.hwm, 0);
`endif
    nxt;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv(v[i].wv, v[i].wd, v[i].rr);
      @(negedge clk);
      chk($sformatf("v%0d wr_ready", i), f.wr_ready, v[i].e_wrdy);
      chk($sformatf("v%0d rd_valid", i), f.rd_valid, v[i].e_rv);
      if (v[i].e_rv) chk($sformatf("v%0d rd_data", i), f.rd_data, v[i].e_rd);
      chk($sformatf("v%0d level", i), f.level, v[i].e_lvl);
      chk($sformatf("v%0d empty", i), f.empty, v[i].e_emp);
      chk($sformatf("v%0d ram_wena", i), f.ram_wena, v[i].e_wena);
      chk($sformatf("v%0d ram_addra", i), f.ram_addra, v[i].e_addra);
      chk($sformatf("v%0d ram_renb", i), f.ram_renb, v[i].e_renb);
      nxt;
    end
    acc = 0;
    for (int i = 0; i < 1024; i++) begin
      drv(1, i, 0);
      @(negedge clk);
      if (f.wr_ready) acc++;
      nxt;
    end
    chk("fill accepted", acc, 1024);
    drv(1, 32'hdead, 0);
    @(negedge clk);
    chk("full flag", f.full, 1);
    chk("full wr_ready", f.wr_ready, 0);
    chk("full ram_wena", f.ram_wena, 0);
    chk("full level", f.level, 1024);
    nxt;
    drv(0, 0, 0);
    @(negedge clk);
    chk("extra push level", f.level, 1024);
    nxt;
    drain(0, 1024);
    @(negedge clk);
    chk("drained level", f.level, 0);
    chk("drained empty", f.empty, 1);
    nxt;
    pops = 0;
    for (int i = 0; i < 40; i++) begin
      drv(1, 5000 + i, 1);
      @(negedge clk);
      if (f.rd_valid) begin
        chk("tput data", f.rd_data, 5000 + pops);
        pops++;
      end
      nxt;
    end
    chk("tput pops", pops, 37);
    drv(0, 0, 0);
    @(negedge clk);
    chk("tput level", f.level, 3);
    nxt;
    drain(5037, 3);
    pushed = 0;
    popped = 0;
    for (int i = 0; i < 3000; i++) begin
      drv(1, 10000 + pushed, 1'($urandom_range(0, 1)));
      @(negedge clk);
      chk("stream level", f.level, pushed - popped);
      if (f.wr_ready) pushed++;
      if (f.rd_valid && f.rd_ready) begin
        chk("stream data", f.rd_data, 10000 + popped);
        popped++;
      end
      nxt;
    end
    drain(10000 + popped, pushed - popped);
    for (int i = 0; i < 5; i++) begin
      drv(1, 20 + i, 0);
      nxt;
    end
    drv(0, 0, 0);
    repeat (6) nxt;
    drv(0, 0, 1);
    @(negedge clk);
    chk("pre-rst level", f.level, 5);
    chk("pre-rst ram_renb", f.ram_renb, 1);
    chk("pre-rst rd_data", f.rd_data, 20);
    nxt;
    drv(0, 0, 0);
    rst = 1'b1;
    #1;
    chk("async rst rd_valid", f.rd_valid, 0);
    chk("async rst level", f.level, 0);
    chk("async rst empty", f.empty, 1);
    nxt;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post-rst rd_valid", f.rd_valid, 0);
      chk("post-rst level", f.level, 0);
      nxt;
    end
    drv(1, 961, 0);
    @(negedge clk);
    chk("961 ram_addra", f.ram_addra, 0);
    nxt;
    drv(0, 0, 0);
    nxt;
    @(negedge clk);
    chk("961 latency rd_valid", f.rd_valid, 0);
    nxt;
    @(negedge clk);
    chk("961 rd_valid", f.rd_valid, 1);
    chk("961 rd_data", f.rd_data, 961);
    nxt;
    drain(961, 1);
    rst = 1'b1;
    nxt;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drv(1, 30 + i, 0);
      nxt;
    end
    drv(0, 0, 0);
    repeat (4) nxt;
    @(negedge clk);
    chk("hwm fill level", f.level, 7);
    nxt;
    drain(30, 7);
    @(negedge clk);
    chk("hwm drain level", f.level, 0);
`ifdef SDPRAM_FIFO_HWM_EN
    chk("hwm value", f.hwm, 7);
`endif
    nxt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
